// File: rtl/mk14_pkg.sv
// rtl/mk14_pkg.sv - shared constants and state encoding for the MK14 front-panel scanner
package mk14_pkg;

  localparam int NUM_DIGITS   = 8;
  localparam int NUM_ROWS     = 4;
  localparam int ROW_BIT_BASE = 4;
  localparam int DIGIT_W      = $clog2(NUM_DIGITS);
  localparam int ROW_W        = $clog2(NUM_ROWS);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    BLANK = 2'd1,
    DWELL = 2'd2,
    EVENT = 2'd3
  } mk14_state_e;

endpackage

// File: rtl/mk14_key_debounce.sv
// rtl/mk14_key_debounce.sv - debounced state and disagreement counter for one key row across all digits
module mk14_key_debounce
  import mk14_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_sample,
  input  logic [DIGIT_W-1:0] i_digit,
  input  logic               i_raw,
  output logic               o_change,
  output logic               o_new_state
);

  logic [NUM_DIGITS-1:0] r_state;
  logic [2:0]            r_cnt [NUM_DIGITS];

  logic       w_diff;
  logic [2:0] w_cnt_inc;

  assign w_diff      = i_raw ^ r_state[i_digit];
  assign w_cnt_inc   = r_cnt[i_digit] + 3'd1;
  assign o_change    = i_sample & w_diff & (w_cnt_inc == 3'(DEBOUNCE_SCANS));
  assign o_new_state = i_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) r_cnt[i] <= 3'd0;
    end else if (i_sample) begin
      if (!w_diff) begin
        r_cnt[i_digit] <= 3'd0;
      end else if (o_change) begin
        r_cnt[i_digit]   <= 3'd0;
        r_state[i_digit] <= i_raw;
      end else begin
        r_cnt[i_digit] <= w_cnt_inc;
      end
    end
  end

endmodule

// File: rtl/mk14_panel_scan.sv
// rtl/mk14_panel_scan.sv - MK14 display/keyboard scanner between the MMU and the panel pins
// Define MK14_PANEL_GHOST_BLANK_EN to insert the anti-ghosting BLANK phase before each dwell.
module mk14_panel_scan
  import mk14_pkg::*;
#(
  parameter int CLOCK_FREQ_MHZ = 50,
  parameter int DIGIT_US       = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [15:0]           display_addr,
  input  logic [7:0]            display_data_in,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] digit_en,
  input  logic [NUM_ROWS-1:0]   key_rows_n,
  output logic                  kbd_write_en,
  output logic [15:0]           kbd_addr,
  output logic [2:0]            kbd_bit,
  output logic                  kbd_pressed
);

  localparam int DWELL_CYCLES = CLOCK_FREQ_MHZ * DIGIT_US;
  localparam int CNT_SPAN     = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W        = $clog2(CNT_SPAN);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  localparam logic [1:0] S_FETCH = FETCH;
  localparam logic [1:0] S_DWELL = DWELL;
  localparam logic [1:0] S_EVENT = EVENT;
`ifdef MK14_PANEL_GHOST_BLANK_EN
  localparam logic [1:0] S_BLANK = BLANK;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`endif

  logic [1:0]          r_state;
  logic [DIGIT_W-1:0]  r_digit;
  logic [CNT_W-1:0]    r_cnt;
  logic [7:0]          r_seg;
  logic [NUM_ROWS-1:0] r_rows_s1;
  logic [NUM_ROWS-1:0] r_rows_s2;
  logic [NUM_ROWS-1:0] r_pend;
  logic [NUM_ROWS-1:0] r_pend_st;

  logic                w_dwell;
  logic                w_event;
  logic                w_sample;
  logic [NUM_ROWS-1:0] w_change;
  logic [NUM_ROWS-1:0] w_new_state;
  logic [NUM_ROWS-1:0] w_pend_rest;
  logic [ROW_W-1:0]    w_ev_row;

  assign w_dwell     = (r_state == S_DWELL);
  assign w_event     = (r_state == S_EVENT);
  assign w_sample    = w_dwell && (r_cnt == DWELL_LAST);
  assign w_pend_rest = r_pend & (r_pend - NUM_ROWS'(1));

  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_row
    mk14_key_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_deb (
      .clk        (clk),
      .rst        (rst),
      .i_sample   (w_sample),
      .i_digit    (r_digit),
      .i_raw      (~r_rows_s2[g]),
      .o_change   (w_change[g]),
      .o_new_state(w_new_state[g])
    );
  end

  // Lowest pending row is reported first, so rows leave in ascending order.
  always_comb begin
    w_ev_row = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (r_pend[i]) w_ev_row = ROW_W'(i);
    end
  end

  assign display_addr = {{(16-DIGIT_W){1'b0}}, r_digit};
  assign seg_out      = r_seg;
  assign digit_en     = w_dwell ? (NUM_DIGITS'(1) << r_digit) : '0;
  assign kbd_write_en = w_event;
  assign kbd_addr     = {{(16-DIGIT_W){1'b0}}, r_digit};
  assign kbd_bit      = 3'(ROW_BIT_BASE) + 3'(w_ev_row);
  assign kbd_pressed  = w_event & r_pend_st[w_ev_row];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_digit   <= '0;
      r_cnt     <= '0;
      r_seg     <= 8'h00;
      r_rows_s1 <= '1;
      r_rows_s2 <= '1;
      r_pend    <= '0;
      r_pend_st <= '0;
    end else begin
      r_rows_s1 <= key_rows_n;
      r_rows_s2 <= r_rows_s1;
      case (r_state)
        S_FETCH: begin
          r_seg <= display_data_in;
          r_cnt <= '0;
`ifdef MK14_PANEL_GHOST_BLANK_EN
          r_state <= S_BLANK;
`else
          r_state <= S_DWELL;
`endif
        end
`ifdef MK14_PANEL_GHOST_BLANK_EN
        S_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            r_cnt   <= '0;
            r_state <= S_DWELL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        S_DWELL: begin
          if (r_cnt == DWELL_LAST) begin
            r_pend    <= w_change;
            r_pend_st <= w_new_state;
            if (|w_change) begin
              r_state <= S_EVENT;
            end else begin
              r_state <= S_FETCH;
              r_digit <= r_digit + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_EVENT: begin
          r_pend <= w_pend_rest;
          if (w_pend_rest == '0) begin
            r_state <= S_FETCH;
            r_digit <= r_digit + 1'b1;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mk14_panel_scan.sv
// tb/tb_mk14_panel_scan.sv - randomized self-checking bench for mk14_panel_scan against a per-cycle timeline model
module tb_mk14_panel_scan;

  localparam int CLK_MHZ = 1;
  localparam int DIG_US  = 10;
  localparam int BLANK_N = 2;
  localparam int DEB     = 3;
  localparam int T       = CLK_MHZ * DIG_US;
`ifdef MK14_PANEL_GHOST_BLANK_EN
  localparam int NB = BLANK_N;
`else
  localparam int NB = 0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] display_addr;
  logic [7:0]  display_data_in;
  logic [7:0]  seg_out;
  logic [7:0]  digit_en;
  logic [3:0]  key_rows_n;
  logic        kbd_write_en;
  logic [15:0] kbd_addr;
  logic [2:0]  kbd_bit;
  logic        kbd_pressed;

  mk14_panel_scan #(
    .CLOCK_FREQ_MHZ(CLK_MHZ),
    .DIGIT_US      (DIG_US),
    .BLANK_CYCLES  (BLANK_N),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .display_addr   (display_addr),
    .display_data_in(display_data_in),
    .seg_out        (seg_out),
    .digit_en       (digit_en),
    .key_rows_n     (key_rows_n),
    .kbd_write_en   (kbd_write_en),
    .kbd_addr       (kbd_addr),
    .kbd_bit        (kbd_bit),
    .kbd_pressed    (kbd_pressed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] mmu_mem [8];
  logic [3:0] held [8];
  bit         deb_st [8][4];
  int         deb_cnt [8][4];
  logic [6:0] evq [$];
  int d, p, frames, strobes;
  bit rnd_mode, arm_rst;
  int total, bad;

  always_comb display_data_in = mmu_mem[display_addr[2:0]];

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (digit %0d phase %0d, t=%0t)", tag, got, exp, d, p, $time);
    end
  endtask

  task automatic model_reset();
    d = 0;
    p = 0;
    evq.delete();
    for (int i = 0; i < 8; i++)
      for (int r = 0; r < 4; r++) begin
        deb_st[i][r]  = 1'b0;
        deb_cnt[i][r] = 0;
      end
  endtask

  // Spec rule: a key flips only after DEB consecutive disagreeing samples.
  task automatic model_sample();
    for (int r = 0; r < 4; r++) begin
      if (held[d][r] != deb_st[d][r]) begin
        deb_cnt[d][r]++;
        if (deb_cnt[d][r] == DEB) begin
          deb_st[d][r]  = held[d][r];
          deb_cnt[d][r] = 0;
          evq.push_back({3'(d), 3'(4 + r), held[d][r]});
        end
      end else begin
        deb_cnt[d][r] = 0;
      end
    end
  endtask

  task automatic drive();
    int k;
    if (p == 0 && rnd_mode) begin
      if (d == 0 && $urandom_range(0, 1) == 1)
        for (int i = 0; i < 8; i++) mmu_mem[i] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 3);
        held[d][k] = ~held[d][k];
      end
    end
    key_rows_n = (p > NB && p <= NB + T) ? ~held[d] : 4'hF;
  endtask

  task automatic chk_reset();
    chk_val("rst_seg", seg_out, 0);
    chk_val("rst_en", digit_en, 0);
    chk_val("rst_daddr", display_addr, 0);
    chk_val("rst_we", kbd_write_en, 0);
    chk_val("rst_kaddr", kbd_addr, 0);
    chk_val("rst_kbit", kbd_bit, 4);
    chk_val("rst_pressed", kbd_pressed, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    model_reset();
    drive();
  endtask

  task automatic step();
    logic [6:0] ev;
    if (kbd_write_en === 1'b1) strobes++;
    if (p == 0) begin
      chk_val("fetch_addr", display_addr, d);
      chk_val("fetch_en", digit_en, 0);
      chk_val("fetch_we", kbd_write_en, 0);
    end else if (p <= NB) begin
      chk_val("blank_en", digit_en, 0);
      chk_val("blank_we", kbd_write_en, 0);
    end else if (p <= NB + T) begin
      chk_val("dwell_en", digit_en, 32'(1) << d);
      chk_val("dwell_seg", seg_out, mmu_mem[d]);
      chk_val("dwell_we", kbd_write_en, 0);
    end else begin
      ev = evq.pop_front();
      chk_val("ev_we", kbd_write_en, 1);
      chk_val("ev_addr", kbd_addr, ev[6:4]);
      chk_val("ev_bit", kbd_bit, ev[3:1]);
      chk_val("ev_pressed", kbd_pressed, ev[0]);
      chk_val("ev_en", digit_en, 0);
    end
    if (arm_rst && p == NB + T + 1) begin
      arm_rst = 1'b0;
      do_reset();
      return;
    end
    if (p == NB + T) model_sample();
    if (p >= NB + T && evq.size() == 0) begin
      p = 0;
      d = (d + 1) % 8;
      if (d == 0) frames++;
    end else begin
      p++;
    end
    drive();
    @(negedge clk);
  endtask

  task automatic run_frames(input int n);
    int target;
    target = frames + n;
    while (frames < target) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    int s;
    int n;
    logic [7:0] init_mem [8];
    init_mem = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
    total = 0; bad = 0; frames = 0; strobes = 0;
    rnd_mode = 1'b0; arm_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mmu_mem[i] = init_mem[i];
      held[i] = 4'h0;
    end
    rst = 1'b1;
    key_rows_n = 4'hF;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset();
    rst = 1'b0;

    run_frames(2);
    chk_val("idle_strobes", strobes, 0);

    held[3][1] = 1'b1;
    s = strobes;
    run_frames(2);
    chk_val("press_early", strobes - s, 0);
    run_frames(1);
    chk_val("press_cnt", strobes - s, 1);

    held[3][1] = 1'b0;
    s = strobes;
    run_frames(2);
    chk_val("release_early", strobes - s, 0);
    run_frames(1);
    chk_val("release_cnt", strobes - s, 1);

    held[2][0] = 1'b1;
    s = strobes;
    run_frames(2);
    held[2][0] = 1'b0;
    run_frames(3);
    chk_val("glitch_cnt", strobes - s, 0);

    held[6] = 4'b1001;
    s = strobes;
    run_frames(3);
    chk_val("dual_cnt", strobes - s, 2);
    held[6] = 4'b0000;
    s = strobes;
    run_frames(3);
    chk_val("dual_rel_cnt", strobes - s, 2);

    held[6] = 4'b1001;
    arm_rst = 1'b1;
    n = 0;
    while (arm_rst && n < 2000) begin
      step();
      n++;
    end
    chk_val("rst_event_hit", arm_rst, 0);
    s = strobes;
    run_frames(2);
    chk_val("post_rst_quiet", strobes - s, 0);
    run_frames(1);
    chk_val("post_rst_rereport", strobes - s, 2);

    rnd_mode = 1'b1;
    run_frames(100);
    rnd_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
